// File: rtl/gnr_attractor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : gnr_attractor_ctrl
//  Purpose  : Sweeps initial states through the Boolean-network node array and
//             reports, per state, the Floyd meet time and the attractor period.
//  Revision : 1.0  initial release
// ============================================================================
module gnr_attractor_ctrl #(
    parameter int N_NODES   = 8,
    parameter int CNT_W     = 16,
    parameter int MAX_STEPS = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_NODES-1:0] init_first,
    input  logic [N_NODES-1:0] init_last,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [N_NODES-1:0] res_init,
    output logic [CNT_W-1:0]   res_meet,
    output logic [CNT_W-1:0]   res_period,
    output logic               res_timeout,
    output logic               busy,
    output logic               done
);

    localparam logic [3:0] c_idle  = 4'd0;
    localparam logic [3:0] c_load  = 4'd1;
    localparam logic [3:0] c_run   = 4'd2;
    localparam logic [3:0] c_cmp   = 4'd3;
    localparam logic [3:0] c_hold  = 4'd4;
    localparam logic [3:0] c_step1 = 4'd5;
    localparam logic [3:0] c_cmp1  = 4'd6;
    localparam logic [3:0] c_out   = 4'd7;
    localparam logic [3:0] c_fin   = 4'd8;

    localparam logic [CNT_W-1:0]   c_max     = CNT_W'(MAX_STEPS);
    localparam logic [CNT_W-1:0]   c_cnt_one = CNT_W'(1);
    localparam logic [N_NODES:0]   c_cur_one = (N_NODES+1)'(1);

    logic [3:0]         r_state;
    // One extra bit so a sweep ending at all-ones never wraps back to zero.
    logic [N_NODES:0]   r_cur;
    logic [N_NODES-1:0] r_last;
    logic [CNT_W-1:0]   r_meet;
    logic [CNT_W-1:0]   r_period;
    logic               r_timeout;

    logic               w_match;
    logic               w_last_state;

    assign w_match      = (s0_vec == s1_vec);
    assign w_last_state = (r_cur == {1'b0, r_last});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_idle;
            r_cur     <= '0;
            r_last    <= '0;
            r_meet    <= '0;
            r_period  <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_cur   <= {1'b0, init_first};
                        r_last  <= init_last;
                        r_state <= (init_first > init_last) ? c_fin : c_load;
                    end
                end
                c_load: begin
                    r_meet    <= '0;
                    r_period  <= '0;
                    r_timeout <= 1'b0;
                    r_state   <= c_run;
                end
                c_run: begin
                    r_meet  <= r_meet + c_cnt_one;
                    r_state <= c_cmp;
                end
                c_cmp: begin
                    if (w_match) begin
                        r_state <= c_hold;
                    end else if (r_meet == c_max) begin
                        r_timeout <= 1'b1;
                        r_period  <= '0;
                        r_state   <= c_out;
                    end else begin
                        r_state <= c_run;
                    end
                end
                c_hold: begin
                    r_state <= c_step1;
                end
                c_step1: begin
                    r_period <= r_period + c_cnt_one;
                    r_state  <= c_cmp1;
                end
                c_cmp1: begin
                    if (w_match) begin
                        r_state <= c_out;
                    end else if (r_period == c_max) begin
                        r_timeout <= 1'b1;
                        r_period  <= '0;
                        r_state   <= c_out;
                    end else begin
                        r_state <= c_step1;
                    end
                end
                c_out: begin
                    if (res_ready) begin
                        if (w_last_state) begin
                            r_state <= c_fin;
                        end else begin
                            r_cur   <= r_cur + c_cur_one;
                            r_state <= c_load;
                        end
                    end
                end
                c_fin: begin
                    r_state <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    // Strobes decode straight from the state register so reset clears them at once.
    assign reset_nos   = (r_state == c_load);
    assign start_s0    = (r_state == c_run);
    assign start_s1    = (r_state == c_run) || (r_state == c_step1);
    assign init_state  = r_cur[N_NODES-1:0];
    assign res_valid   = (r_state == c_out);
    assign res_init    = r_cur[N_NODES-1:0];
    assign res_meet    = r_meet;
    assign res_period  = r_period;
    assign res_timeout = r_timeout;
    assign busy        = (r_state != c_idle);
    assign done        = (r_state == c_fin);

endmodule
`default_nettype wire

// File: tb/tb_gnr_attractor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gnr_attractor_ctrl
//  Purpose  : Directed bench for gnr_attractor_ctrl driving a 3-node stub array.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gnr_attractor_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  init_first;
    logic [2:0]  init_last;
    logic        reset_nos;
    logic [2:0]  init_state;
    logic        start_s0;
    logic        start_s1;
    logic [2:0]  s0_vec;
    logic [2:0]  s1_vec;
    logic        res_valid;
    logic        res_ready;
    logic [2:0]  res_init;
    logic [15:0] res_meet;
    logic [15:0] res_period;
    logic        res_timeout;
    logic        busy;
    logic        done;

    int          checks;
    int          errors;
    logic [1:0]  net;
    int          load_cnt;
    bit          overlap;

    gnr_attractor_ctrl #(
        .N_NODES   (3),
        .CNT_W     (16),
        .MAX_STEPS (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .init_first  (init_first),
        .init_last   (init_last),
        .reset_nos   (reset_nos),
        .init_state  (init_state),
        .start_s0    (start_s0),
        .start_s1    (start_s1),
        .s0_vec      (s0_vec),
        .s1_vec      (s1_vec),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_init    (res_init),
        .res_meet    (res_meet),
        .res_period  (res_period),
        .res_timeout (res_timeout),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub next-state: 0 = identity, 1 = rotate-left, 2 = x+1 mod 8.
    function automatic logic [2:0] f_next(input logic [2:0] x);
        case (net)
            2'd0:    f_next = x;
            2'd1:    f_next = {x[1:0], x[2]};
            default: f_next = x + 3'd1;
        endcase
    endfunction

    // Node array stub: the fast copy advances two network steps per strobe,
    // the slow copy one, giving the classic 2:1 Floyd ratio.
    always @(posedge clk) begin
        if (reset_nos) begin
            s0_vec <= init_state;
            s1_vec <= init_state;
        end else begin
            if (start_s0) s0_vec <= f_next(s0_vec);
            if (start_s1) s1_vec <= f_next(f_next(s1_vec));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (reset_nos) load_cnt = load_cnt + 1;
            if (reset_nos && (start_s0 || start_s1)) overlap = 1'b1;
            if (res_valid && (reset_nos || start_s0 || start_s1)) overlap = 1'b1;
        end
    end

    task automatic pulse_start(input logic [2:0] f, input logic [2:0] l);
        @(negedge clk);
        init_first = f;
        init_last  = l;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic accept();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({reset_nos, start_s0, start_s1, res_valid, busy, done, res_timeout} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {reset_nos, start_s0, start_s1, res_valid, busy, done, res_timeout});
        end
        checks++;
        if ({init_state, res_init, res_meet, res_period} !== 38'd0) begin
            errors++;
            $display("FAIL reset_data: got init=%0d meet=%0d period=%0d expected 0",
                     init_state, res_meet, res_period);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fixed_point();
        bit ok;
        net = 2'd0;
        pulse_start(3'd5, 3'd5);
        wait_valid(ok);
        checks++;
        if (!ok || res_init !== 3'd5 || res_meet !== 16'd1 || res_period !== 16'd1 || res_timeout !== 1'b0) begin
            errors++;
            $display("FAIL fixed_rec: got valid=%0d init=%0d meet=%0d period=%0d to=%0d expected 1 5 1 1 0",
                     ok, res_init, res_meet, res_period, res_timeout);
        end
        accept();
        checks++;
        if (done !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL fixed_done: got done=%0d valid=%0d expected 1 0", done, res_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fixed_idle: got done=%0d busy=%0d expected 0 0", done, busy);
        end
    endtask

    task automatic test_rotate_back_to_back();
        bit ok;
        net = 2'd1;
        pulse_start(3'd0, 3'd1);
        wait_valid(ok);
        checks++;
        if (!ok || res_init !== 3'd0 || res_meet !== 16'd1 || res_period !== 16'd1 || res_timeout !== 1'b0) begin
            errors++;
            $display("FAIL rot_rec0: got valid=%0d init=%0d meet=%0d period=%0d to=%0d expected 1 0 1 1 0",
                     ok, res_init, res_meet, res_period, res_timeout);
        end
        accept();
        checks++;
        if (reset_nos !== 1'b1 || res_valid !== 1'b0 || init_state !== 3'd1) begin
            errors++;
            $display("FAIL rot_load: got reset_nos=%0d valid=%0d init_state=%0d expected 1 0 1",
                     reset_nos, res_valid, init_state);
        end
        wait_valid(ok);
        checks++;
        if (!ok || res_init !== 3'd1 || res_meet !== 16'd3 || res_period !== 16'd3 || res_timeout !== 1'b0) begin
            errors++;
            $display("FAIL rot_rec1: got valid=%0d init=%0d meet=%0d period=%0d to=%0d expected 1 1 3 3 0",
                     ok, res_init, res_meet, res_period, res_timeout);
        end
        accept();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL rot_done: got %0d expected 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit ok;
        net = 2'd2;
        pulse_start(3'd0, 3'd0);
        wait_valid(ok);
        checks++;
        if (!ok || res_timeout !== 1'b1 || res_period !== 16'd0 || res_meet !== 16'd4) begin
            errors++;
            $display("FAIL timeout_rec: got valid=%0d to=%0d period=%0d meet=%0d expected 1 1 0 4",
                     ok, res_timeout, res_period, res_meet);
        end
        accept();
        @(negedge clk);
    endtask

    task automatic test_all_ones();
        bit ok;
        int loads_before;
        net = 2'd0;
        loads_before = load_cnt;
        pulse_start(3'd7, 3'd7);
        wait_valid(ok);
        checks++;
        if (!ok || res_init !== 3'd7 || res_meet !== 16'd1) begin
            errors++;
            $display("FAIL ones_rec: got valid=%0d init=%0d meet=%0d expected 1 7 1", ok, res_init, res_meet);
        end
        accept();
        checks++;
        if (done !== 1'b1 || load_cnt - loads_before !== 1) begin
            errors++;
            $display("FAIL ones_nowrap: got done=%0d loads=%0d expected 1 1", done, load_cnt - loads_before);
        end
        @(negedge clk);
    endtask

    task automatic test_empty_range();
        int loads_before;
        loads_before = load_cnt;
        pulse_start(3'd6, 3'd2);
        checks++;
        if (busy !== 1'b1 || done !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_fin: got busy=%0d done=%0d valid=%0d expected 1 1 0", busy, done, res_valid);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || load_cnt !== loads_before) begin
            errors++;
            $display("FAIL empty_idle: got busy=%0d done=%0d loads=%0d expected 0 0 0",
                     busy, done, load_cnt - loads_before);
        end
    endtask

    task automatic test_ready_hold();
        bit ok;
        bit bad;
        int loads_before;
        net = 2'd1;
        pulse_start(3'd1, 3'd1);
        wait_valid(ok);
        loads_before = load_cnt;
        bad = !ok;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                init_first = 3'd0;
                init_last  = 3'd7;
                start      = 1'b1;
            end else begin
                start      = 1'b0;
            end
            @(negedge clk);
            if (res_valid !== 1'b1 || res_init !== 3'd1 || res_meet !== 16'd3 || res_period !== 16'd3
                || reset_nos || start_s0 || start_s1)
                bad = 1'b1;
        end
        start = 1'b0;
        checks++;
        if (bad || load_cnt !== loads_before) begin
            errors++;
            $display("FAIL hold_stable: got bad=%0d new_loads=%0d expected 0 0", bad, load_cnt - loads_before);
        end
        accept();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL hold_ignore_start: got done=%0d expected 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        bit seen;
        net = 2'd2;
        pulse_start(3'd0, 3'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (start_s1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (!seen || {reset_nos, start_s0, start_s1, res_valid, busy, done} !== 6'b0) begin
            errors++;
            $display("FAIL midrun_reset: got seen=%0d outs=%b expected 1 000000", seen,
                     {reset_nos, start_s0, start_s1, res_valid, busy, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        net   = 2'd0;
        pulse_start(3'd3, 3'd3);
        wait_valid(ok);
        checks++;
        if (!ok || res_init !== 3'd3 || res_meet !== 16'd1 || res_period !== 16'd1 || res_timeout !== 1'b0) begin
            errors++;
            $display("FAIL midrun_restart: got valid=%0d init=%0d meet=%0d period=%0d to=%0d expected 1 3 1 1 0",
                     ok, res_init, res_meet, res_period, res_timeout);
        end
        accept();
        @(negedge clk);
    endtask

    task automatic test_strobe_exclusive();
        checks++;
        if (overlap !== 1'b0) begin
            errors++;
            $display("FAIL strobe_excl: got overlap=%0d expected 0", overlap);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        net        = 2'd0;
        load_cnt   = 0;
        overlap    = 1'b0;
        rst_n      = 1'b0;
        start      = 1'b0;
        init_first = 3'd0;
        init_last  = 3'd0;
        res_ready  = 1'b0;
        test_reset();
        test_fixed_point();
        test_rotate_back_to_back();
        test_timeout();
        test_all_ones();
        test_empty_range();
        test_ready_hold();
        test_reset_mid_run();
        test_strobe_exclusive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
